// File: rtl/centroid_tracker.sv
// Red-target centroid tracker: accumulates target pixel coordinates per frame and divides by the pixel count.
// Optional crosshair overlay outputs are built when CENTROID_TRACKER_OVERLAY_EN is defined.
module centroid_tracker #(
   parameter logic [9:0]  R_MIN     = 10'd600,
   parameter logic [9:0]  MARGIN    = 10'd200,
   parameter logic [19:0] MIN_COUNT = 20'd64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   input  logic [10:0] pix_x,
   input  logic [10:0] pix_y,
   input  logic [9:0]  pix_r,
   input  logic [9:0]  pix_g,
   input  logic [9:0]  pix_b,
   input  logic        frame_end,
   output logic [9:0]  cent_x,
   output logic [8:0]  cent_y,
   output logic        found,
   output logic        cent_valid,
   output logic        busy
`ifdef CENTROID_TRACKER_OVERLAY_EN
   ,
   output logic [9:0]  ovl_r,
   output logic [9:0]  ovl_g,
   output logic [9:0]  ovl_b
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DIV_X = 2'd1;
   localparam logic [1:0] DIV_Y = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state;
   logic [4:0]  bit_idx;
   logic        last_bit;
   logic        target;
   logic [10:0] g_lim, b_lim;
   logic [27:0] sum_x, sum_y, sum_x_n, sum_y_n;
   logic [19:0] cnt, cnt_n;
   logic [27:0] snap_y;
   logic [19:0] snap_cnt;
   logic [27:0] div_q, q_next;
   logic [19:0] div_rem, rem_next;
   logic [20:0] trial_sh, trial_diff;
   logic        trial_ok;
   logic [9:0]  quot_x;

   assign g_lim  = {1'b0, pix_g} + {1'b0, MARGIN};
   assign b_lim  = {1'b0, pix_b} + {1'b0, MARGIN};
   assign target = pix_valid && (pix_x < 11'd640) && (pix_y < 11'd480) && (pix_r > R_MIN) &&
                   ({1'b0, pix_r} > g_lim) && ({1'b0, pix_r} > b_lim);

   assign sum_x_n = sum_x + (target ? {17'd0, pix_x} : 28'd0);
   assign sum_y_n = sum_y + (target ? {17'd0, pix_y} : 28'd0);
   assign cnt_n   = cnt + {19'd0, target};

   assign busy     = (state == DIV_X) || (state == DIV_Y);
   assign last_bit = (bit_idx == 5'd27);

   // restoring divide step: shift in the next dividend bit and subtract the count if it fits
   assign trial_sh   = {div_rem, div_q[27]};
   assign trial_diff = trial_sh - {1'b0, snap_cnt};
   assign trial_ok   = (trial_sh >= {1'b0, snap_cnt});
   assign rem_next   = trial_ok ? trial_diff[19:0] : trial_sh[19:0];
   assign q_next     = {div_q[26:0], trial_ok};

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_idx    <= '0;
         sum_x      <= '0;
         sum_y      <= '0;
         cnt        <= '0;
         snap_y     <= '0;
         snap_cnt   <= '0;
         div_q      <= '0;
         cent_x     <= '0;
         cent_y     <= '0;
         found      <= 1'b0;
         cent_valid <= 1'b0;
      end else begin
         cent_valid <= 1'b0;
         if (frame_end) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
         end else begin
            sum_x <= sum_x_n;
            sum_y <= sum_y_n;
            cnt   <= cnt_n;
         end
         // the divider owns the snapshot while busy, so a frame ending mid-divide is dropped
         if (frame_end && !busy) begin
            snap_y   <= sum_y_n;
            snap_cnt <= cnt_n;
         end
         case (state)
            IDLE: begin
               if (frame_end) begin
                  div_q <= sum_x_n;
                  if (cnt_n >= MIN_COUNT) begin
                     state   <= DIV_X;
                     bit_idx <= '0;
                  end else begin
                     state      <= DONE;
                     found      <= 1'b0;
                     cent_valid <= 1'b1;
                  end
               end
            end
            DIV_X: begin
               bit_idx <= bit_idx + 5'd1;
               div_q   <= q_next;
               if (last_bit) begin
                  state   <= DIV_Y;
                  bit_idx <= '0;
                  div_q   <= snap_y;
               end
            end
            DIV_Y: begin
               bit_idx <= bit_idx + 5'd1;
               div_q   <= q_next;
               if (last_bit) begin
                  state      <= DONE;
                  cent_x     <= quot_x;
                  cent_y     <= q_next[8:0];
                  found      <= 1'b1;
                  cent_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      case (state)
         IDLE:  div_rem <= '0;
         DIV_X: begin
            div_rem <= last_bit ? 20'd0 : rem_next;
            if (last_bit) quot_x <= q_next[9:0];
         end
         DIV_Y: div_rem <= rem_next;
         default: ;
      endcase
   end

`ifdef CENTROID_TRACKER_OVERLAY_EN
   // green crosshair through the last detected centroid, one cycle behind the pixel stream
   always_ff @(posedge clk) begin
      if (reset) begin
         ovl_r <= '0;
         ovl_g <= '0;
         ovl_b <= '0;
      end else if (found && ((pix_x == {1'b0, cent_x}) || (pix_y == {2'b0, cent_y}))) begin
         ovl_r <= 10'd0;
         ovl_g <= 10'd1023;
         ovl_b <= 10'd0;
      end else begin
         ovl_r <= pix_r;
         ovl_g <= pix_g;
         ovl_b <= pix_b;
      end
   end
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: a frame-level reference model checked every cycle,
// plus hand-computed centroids, latencies and reset behaviour.
module tb_centroid_tracker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pix_valid = 1'b0;
   logic [10:0] pix_x = '0;
   logic [10:0] pix_y = '0;
   logic [9:0]  pix_r = '0;
   logic [9:0]  pix_g = '0;
   logic [9:0]  pix_b = '0;
   logic        frame_end = 1'b0;
   logic [9:0]  cent_x;
   logic [8:0]  cent_y;
   logic        found;
   logic        cent_valid;
   logic        busy;
`ifdef CENTROID_TRACKER_OVERLAY_EN
   logic [9:0]  ovl_r, ovl_g, ovl_b;
`endif

   always #5 clk = ~clk;

   centroid_tracker dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_end(frame_end),
      .cent_x(cent_x), .cent_y(cent_y), .found(found), .cent_valid(cent_valid), .busy(busy)
`ifdef CENTROID_TRACKER_OVERLAY_EN
      , .ovl_r(ovl_r), .ovl_g(ovl_g), .ovl_b(ovl_b)
`endif
   );

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: frame sums with plain integers, result scheduled by the stated latencies.
   int edge_n = 0;
   int m_sx = 0, m_sy = 0, m_cnt = 0;
   bit m_pend = 0, m_det = 0, m_rf = 0, engaged = 0;
   int m_pend_edge = 0, m_start = 0, m_rx = 0, m_ry = 0;
   int e_cx = 0, e_cy = 0;
   bit e_found = 0, e_valid = 0, e_busy = 0;

   function automatic bit is_target(int v, int x, int y, int r, int g, int b);
      return (v != 0) && (x < 640) && (y < 480) && (r > 600) && (r - g > 200) && (r - b > 200);
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (reset) begin
         m_sx = 0; m_sy = 0; m_cnt = 0; m_pend = 0;
         e_cx = 0; e_cy = 0; e_found = 0; e_valid = 0; e_busy = 0;
      end else begin
         engaged = m_pend && (edge_n - 1 <= m_pend_edge);
         if (is_target(int'(pix_valid), int'(pix_x), int'(pix_y), int'(pix_r), int'(pix_g), int'(pix_b))) begin
            m_sx += int'(pix_x);
            m_sy += int'(pix_y);
            m_cnt++;
         end
         if (frame_end) begin
            if (!engaged) begin
               m_pend  = 1;
               m_start = edge_n;
               if (m_cnt >= 64) begin
                  m_det = 1; m_rf = 1; m_pend_edge = edge_n + 56;
                  m_rx = (m_sx / m_cnt) % 1024;
                  m_ry = (m_sy / m_cnt) % 512;
               end else begin
                  m_det = 0; m_rf = 0; m_pend_edge = edge_n;
                  m_rx = e_cx; m_ry = e_cy;
               end
            end
            m_sx = 0; m_sy = 0; m_cnt = 0;
         end
         e_valid = m_pend && (edge_n == m_pend_edge);
         if (e_valid) begin
            e_found = m_rf; e_cx = m_rx; e_cy = m_ry;
         end
         e_busy = m_pend && m_det && (edge_n >= m_start) && (edge_n <= m_start + 55);
      end
   end

   always @(negedge clk) begin
      check("cent_valid", int'(cent_valid), int'(e_valid));
      check("busy", int'(busy), int'(e_busy));
      check("found", int'(found), int'(e_found));
      check("cent_x", int'(cent_x), e_cx);
      check("cent_y", int'(cent_y), e_cy);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_pix(input int x, input int y, input int r, input int g, input int b,
                          input bit v, input bit fe);
      tick();
      pix_valid = v; frame_end = fe;
      pix_x = 11'(x); pix_y = 11'(y);
      pix_r = 10'(r); pix_g = 10'(g); pix_b = 10'(b);
   endtask

   task automatic idle();
      tick();
      pix_valid = 1'b0;
      frame_end = 1'b0;
   endtask

   task automatic block(input int x0, input int y0, input int n, input bit fe_last);
      for (int j = 0; j < n; j++)
         for (int i = 0; i < n; i++)
            put_pix(x0 + i, y0 + j, 1023, 0, 0, 1'b1, fe_last && (i == n - 1) && (j == n - 1));
   endtask

   // caller is in cycle k0 after the frame_end cycle; returns the cycle cent_valid is seen
   task automatic await_valid(input int k0, output int k);
      bit seen = 0;
      k = k0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (cent_valid) seen = 1;
         else begin
            tick();
            k++;
         end
      end
   endtask

   int k;
   int pulses;

   initial begin
      repeat (3) tick();
      check("rst_cent_x", int'(cent_x), 0);
      check("rst_found", int'(found), 0);
      check("rst_busy", int'(busy), 0);
      reset = 1'b0;

      // non-targets that must not contribute, then an 8x8 block with frame_end on its last pixel
      put_pix(10, 10, 700, 600, 0, 1'b1, 1'b0);
      put_pix(650, 10, 1023, 0, 0, 1'b1, 1'b0);
      put_pix(10, 480, 1023, 0, 0, 1'b1, 1'b0);
      put_pix(10, 10, 1023, 0, 0, 1'b0, 1'b0);
      put_pix(10, 10, 600, 0, 0, 1'b1, 1'b0);
      put_pix(0, 0, 601, 401, 400, 1'b1, 1'b0);
      put_pix(0, 0, 601, 400, 401, 1'b1, 1'b0);
      block(100, 50, 8, 1'b1);
      idle();
      await_valid(1, k);
      check("det_latency", k, 57);
      check("det_cent_x", int'(cent_x), 103);
      check("det_cent_y", int'(cent_y), 53);
      check("det_found", int'(found), 1);
      check("model_cent_x", e_cx, 103);

`ifdef CENTROID_TRACKER_OVERLAY_EN
      put_pix(103, 200, 5, 6, 7, 1'b1, 1'b0);
      tick();
      check("ovl_r_cross", int'(ovl_r), 0);
      check("ovl_g_cross", int'(ovl_g), 1023);
      put_pix(1, 1, 5, 6, 7, 1'b1, 1'b0);
      tick();
      check("ovl_g_pass", int'(ovl_g), 6);
      check("ovl_b_pass", int'(ovl_b), 7);
      idle();
`endif

      // too few targets: immediate no-detection, centroid held
      for (int i = 0; i < 10; i++) put_pix(5, 5, 1023, 0, 0, 1'b1, i == 9);
      idle();
      await_valid(1, k);
      check("nodet_latency", k, 1);
      check("nodet_found", int'(found), 0);
      check("nodet_cent_x", int'(cent_x), 103);
      check("nodet_cent_y", int'(cent_y), 53);

      // edge of the active area with thresholds just met
      for (int i = 0; i < 64; i++) put_pix(639, 479, 601, 400, 400, 1'b1, i == 63);
      idle();
      await_valid(1, k);
      check("edge_cent_x", int'(cent_x), 639);
      check("edge_cent_y", int'(cent_y), 479);

      // diagonal scatter: truncating division of 18144/64 and 14112/64
      for (int i = 0; i < 64; i++) put_pix(9 * i, 7 * i, 1023, 0, 0, 1'b1, i == 63);
      idle();
      await_valid(1, k);
      check("diag_latency", k, 57);
      check("diag_cent_x", int'(cent_x), 283);
      check("diag_cent_y", int'(cent_y), 220);

      // second frame_end 20 cycles into the divide is discarded and its pixels cleared
      block(200, 300, 8, 1'b0);
      put_pix(0, 0, 0, 0, 0, 1'b0, 1'b1);
      for (int i = 1; i < 20; i++) put_pix(10, 10, 1023, 0, 0, 1'b1, 1'b0);
      put_pix(0, 0, 0, 0, 0, 1'b0, 1'b1);
      idle();
      await_valid(21, k);
      check("ovl_fe_latency", k, 57);
      check("ovl_fe_cent_x", int'(cent_x), 203);
      check("ovl_fe_cent_y", int'(cent_y), 303);
      for (int i = 0; i < 50; i++) put_pix(20, 20, 1023, 0, 0, 1'b1, i == 49);
      idle();
      await_valid(1, k);
      check("cleared_latency", k, 1);
      check("cleared_found", int'(found), 0);
      check("cleared_cent_x", int'(cent_x), 203);

      // reset in the middle of the divide
      block(300, 100, 8, 1'b1);
      idle();
      repeat (29) tick();
      @(negedge clk);
      check("busy_mid", int'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_valid", int'(cent_valid), 0);
      check("abort_cent_x", int'(cent_x), 0);
      check("abort_cent_y", int'(cent_y), 0);
      check("abort_found", int'(found), 0);
      pulses = 0;
      repeat (70) begin
         @(negedge clk);
         if (cent_valid) pulses++;
      end
      check("abort_no_pulse", pulses, 0);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
